// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 sizes, FSM states, request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return !ok;
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: load extraction with sign/zero extension and sub-word store merging.
// Purely combinational, zero latency, no flow control.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] sdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] mask;
  logic [31:0] sdata_sh;

  assign sh       = {offset, 3'b000};
  assign lane     = word >> sh;
  assign sdata_sh = sdata << sh;

  always_comb begin
    ldata = '0;
    case (funct3)
      F3_B:    ldata = {{24{lane[7]}}, lane[7:0]};
      F3_H:    ldata = {{16{lane[15]}}, lane[15:0]};
      F3_W:    ldata = word;
      F3_BU:   ldata = {24'h0, lane[7:0]};
      F3_HU:   ldata = {16'h0, lane[15:0]};
      default: ldata = '0;
    endcase
  end

  always_comb begin
    mask = 32'hFFFF_FFFF;
    case (funct3[1:0])
      2'b00:   mask = 32'h0000_00FF << sh;
      2'b01:   mask = 32'h0000_FFFF << sh;
      default: mask = 32'hFFFF_FFFF;
    endcase
  end

  assign mdata = (word & ~mask) | (sdata_sh & mask);

endmodule

// File: rtl/lsu_dm.sv
// Load/store unit driving a 2**DM_AW x 32 data memory; response strobe 2 cycles after accept.
// One request in flight: req_ready only in IDLE, responses are not backpressured.
module lsu_dm
  import lsu_pkg::*;
#(
  parameter int DM_AW = 5,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [2:0]       req_funct3,
  output logic             resp_valid,
  output logic [XLEN-1:0]  resp_rdata,
  output logic             resp_err,
  output logic [DM_AW-1:0] addressDM,
  output logic [XLEN-1:0]  wd,
  output logic             we,
  input  logic [XLEN-1:0]  rd
);

  state_t            state;
  logic              cap_we;
  logic              cap_err;
  logic [DM_AW+1:0]  cap_addr;
  logic [XLEN-1:0]   cap_wdata;
  logic [2:0]        cap_f3;
  logic              req_err;
  logic              store_ok;
  logic [XLEN-1:0]   ldata;
  logic [XLEN-1:0]   mdata;

  assign req_ready = rst_n && (state == ST_IDLE);

  assign req_err = f3_illegal(req_we, req_funct3)
                || misaligned(req_funct3, req_addr[1:0])
                || (req_addr[XLEN-1:DM_AW+2] != '0);

  // Write data depends on the asynchronous rd in ACCESS, so the strobe and merge stay combinational.
  assign store_ok  = (state == ST_ACCESS) && cap_we && !cap_err;
  assign we        = rst_n && store_ok;
  assign wd        = store_ok ? mdata : '0;
  assign addressDM = cap_addr[DM_AW+1:2];

  lsu_align u_align (
    .word   (rd),
    .offset (cap_addr[1:0]),
    .funct3 (cap_f3),
    .sdata  (cap_wdata),
    .ldata  (ldata),
    .mdata  (mdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cap_we     <= 1'b0;
      cap_err    <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_f3     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_err   <= req_err;
            cap_addr  <= req_addr[DM_AW+1:0];
            cap_wdata <= req_wdata;
            cap_f3    <= req_funct3;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          resp_rdata <= (cap_we || cap_err) ? '0 : ldata;
          resp_err   <= cap_err;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dm.sv
// Bench for lsu_dm: directed vector table, back-to-back and reset corner cases, then random traffic vs a byte-level model.
module tb_lsu_dm;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [4:0]  addressDM;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;

  lsu_dm #(.DM_AW(5), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .addressDM  (addressDM),
    .wd         (wd),
    .we         (we),
    .rd         (rd)
  );

  always #5 clk = ~clk;

  // Data memory: asynchronous read, synchronous write.
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  int          wcount = 0;

  assign rd = mem[addressDM];
  always @(posedge clk) if (we) mem[addressDM] <= wd;
  always @(posedge clk) if (we) wcount <= wcount + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic logic m_err(input logic st, input logic [31:0] a, input logic [2:0] f3);
    int unsigned size;
    if (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
    size = 1 << f3[1:0];
    if (a % size != 0) return 1'b1;
    return a >= 32'd128;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
    logic [7:0] b [4];
    int off;
    off = int'(a % 4);
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    case (f3)
      3'd0:    return {{24{b[off][7]}}, b[off]};
      3'd1:    return {{16{b[off+1][7]}}, b[off+1], b[off]};
      3'd2:    return w;
      3'd4:    return {24'h0, b[off]};
      3'd5:    return {16'h0, b[off+1], b[off]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] a,
                                          input logic [2:0] f3, input logic [31:0] wdat);
    logic [7:0] b [4];
    int n;
    int off;
    off = int'(a % 4);
    n = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    for (int i = 0; i < n; i++) b[off + i] = wdat[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Issue one request and check the whole accept/ACCESS/RESP sequence; called at posedge+1.
  task automatic do_req(input string tag, input logic st, input logic [31:0] a, input logic [31:0] wdat,
                        input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_er,
                        input logic exp_wr, input logic [31:0] exp_wd);
    int n;
    int w0;
    n = 0;
    req_valid  = 1'b1;
    req_we     = st;
    req_addr   = a;
    req_wdata  = wdat;
    req_funct3 = f3;
    #0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("%s.ready", tag), {31'b0, req_ready}, 32'd1);
    w0 = wcount;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk($sformatf("%s.access_we", tag), {31'b0, we}, {31'b0, exp_wr});
    chk($sformatf("%s.access_rvld", tag), {31'b0, resp_valid}, 32'd0);
    chk($sformatf("%s.access_rdy", tag), {31'b0, req_ready}, 32'd0);
    if (exp_wr) begin
      chk($sformatf("%s.wd", tag), wd, exp_wd);
      chk($sformatf("%s.addr", tag), {27'b0, addressDM}, {27'b0, a[6:2]});
    end
    @(posedge clk); #1;
    chk($sformatf("%s.resp_valid", tag), {31'b0, resp_valid}, 32'd1);
    chk($sformatf("%s.rdata", tag), resp_rdata, exp_rd);
    chk($sformatf("%s.err", tag), {31'b0, resp_err}, {31'b0, exp_er});
    @(posedge clk); #1;
    chk($sformatf("%s.resp_drop", tag), {31'b0, resp_valid}, 32'd0);
    chk($sformatf("%s.writes", tag), 32'(wcount - w0), {31'b0, exp_wr});
  endtask

  typedef struct {
    logic        st;
    logic [31:0] a;
    logic [31:0] wdat;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_er;
    logic        exp_wr;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t        tbl [14];
  logic [31:0] ba [4];
  logic [2:0]  bf [4];
  logic [31:0] bexp [4];
  int          last;
  int          idx;
  int          nresp;
  logic        acc;
  int          w0;
  logic        r_st;
  logic [31:0] r_a;
  logic [31:0] r_wd;
  logic [2:0]  r_f3;
  logic        r_er;
  logic [31:0] r_old;
  int          r_sel;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    mem[1] = 32'h8081_82F3;
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];

    tbl[0]  = '{1'b0, 32'h4,  32'h0,        F3_W,   32'h808182F3, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h4,  32'h0,        F3_B,   32'hFFFFFFF3, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h7,  32'h0,        F3_BU,  32'h00000080, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h6,  32'h0,        F3_H,   32'hFFFF8081, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h4,  32'h0,        F3_HU,  32'h000082F3, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 32'h5,  32'h000000AA, F3_B,   32'h0,        1'b0, 1'b1, 32'h8081AAF3};
    tbl[6]  = '{1'b0, 32'h4,  32'h0,        F3_W,   32'h8081AAF3, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 32'h6,  32'h00001234, F3_H,   32'h0,        1'b0, 1'b1, 32'h1234AAF3};
    tbl[8]  = '{1'b0, 32'h4,  32'h0,        F3_W,   32'h1234AAF3, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 32'h5,  32'h0000BEEF, F3_H,   32'h0,        1'b1, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 32'h6,  32'hCAFEF00D, F3_W,   32'h0,        1'b1, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h80, 32'h0,        F3_W,   32'h0,        1'b1, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 32'h4,  32'h0,        3'b011, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 32'h4,  32'h0,        F3_W,   32'h1234AAF3, 1'b0, 1'b0, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst.we", {31'b0, we}, 32'd0);
    chk("rst.wd", wd, 32'd0);
    chk("rst.addressDM", {27'b0, addressDM}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.ready_after", {31'b0, req_ready}, 32'd1);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      do_req($sformatf("tbl%0d", i), tbl[i].st, tbl[i].a, tbl[i].wdat, tbl[i].f3,
             tbl[i].exp_rd, tbl[i].exp_er, tbl[i].exp_wr, tbl[i].exp_wd);
      if (tbl[i].exp_wr) ref_mem[tbl[i].a[6:2]] = tbl[i].exp_wd;
    end
    chk("tbl.mem1", mem[1], 32'h1234AAF3);

    // req_valid held high across four loads
    ba[0] = 32'h4; bf[0] = F3_W;
    ba[1] = 32'h5; bf[1] = F3_B;
    ba[2] = 32'h6; bf[2] = F3_HU;
    ba[3] = 32'h7; bf[3] = F3_BU;
    for (int i = 0; i < 4; i++) bexp[i] = m_load(ref_mem[1], ba[i], bf[i]);
    last = -1; idx = 0; nresp = 0;
    req_we = 1'b0; req_addr = ba[0]; req_funct3 = bf[0]; req_valid = 1'b1;
    #0;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) begin
        if (nresp < 4) chk($sformatf("b2b.rdata%0d", nresp), resp_rdata, bexp[nresp]);
        nresp++;
      end
      acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (last >= 0) chk("b2b.gap", 32'(c - last), 32'd3);
        last = c;
        idx++;
        if (idx < 4) begin
          req_addr = ba[idx];
          req_funct3 = bf[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("b2b.nresp", 32'(nresp), 32'd4);

    // Reset asserted while a store is in ACCESS
    w0 = wcount;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hDEADBEEF; req_funct3 = F3_W;
    #0;
    chk("rstmid.ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #0;
    chk("rstmid.we_gated", {31'b0, we}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #0;
    chk("rstmid.ready_after", {31'b0, req_ready}, 32'd1);
    chk("rstmid.no_resp0", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rstmid.no_resp1", {31'b0, resp_valid}, 32'd0);
    chk("rstmid.mem2", mem[2], ref_mem[2]);
    chk("rstmid.writes", 32'(wcount - w0), 32'd0);

    // Random traffic against the byte-level model
    for (int k = 0; k < 80; k++) begin
      r_st  = 1'($urandom_range(0, 1));
      r_f3  = 3'($urandom_range(0, 7));
      r_wd  = $urandom;
      r_sel = int'($urandom_range(0, 9));
      if (r_sel == 0)      r_a = $urandom;
      else if (r_sel == 1) r_a = 32'h80 + $urandom_range(0, 127);
      else                 r_a = $urandom_range(0, 127);
      r_er  = m_err(r_st, r_a, r_f3);
      r_old = ref_mem[r_a[6:2]];
      do_req($sformatf("rnd%0d", k), r_st, r_a, r_wd, r_f3,
             (r_st || r_er) ? 32'h0 : m_load(r_old, r_a, r_f3),
             r_er, r_st && !r_er, m_store(r_old, r_a, r_f3, r_wd));
      if (r_st && !r_er) ref_mem[r_a[6:2]] = m_store(r_old, r_a, r_f3, r_wd);
    end

    for (int i = 0; i < 32; i++) chk($sformatf("final.mem%0d", i), mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
